// File: rtl/seq_pkg.sv
// Shared types and constants for the pc_sequencer fetch/execute block.
// Holds the FSM state enum, default widths and the branch-offset table.
package seq_pkg;

    localparam int DEF_PC_W  = 10;
    localparam int DEF_TGT_W = 5;
    localparam int DEF_OFF_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        EXEC     = 3'd2,
        WAIT_MEM = 3'd3,
        HALT     = 3'd4
    } seq_state_t;

    typedef logic signed [DEF_OFF_W-1:0] br_off_t;

    // Signed PC offsets selected by the instruction's branch-target field.
    localparam br_off_t BR_OFFSETS [0:(2**DEF_TGT_W)-1] = '{
        8'sd3,  -8'sd2, 8'sd16, 8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,
        8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,
        8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,
        8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: instruction field index -> signed PC offset.
module branch_lut
    import seq_pkg::*;
#(
    parameter int TGT_W = DEF_TGT_W
) (
    input  logic [TGT_W-1:0] idx,
    output br_off_t          off
);

    // Table read from the package constant array.
    always_comb begin
        off = BR_OFFSETS[idx];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the program counter.
// Optional macro SEQ_CYCLE_COUNT_EN adds a saturating 16-bit CycleCount output.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int TGT_W = DEF_TGT_W,
    parameter int OFF_W = DEF_OFF_W
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    output logic            Done,
    output logic            InstrRd,
    output logic [PC_W-1:0] InstrAddr,
    output logic            ExecEn,
    input  logic            Branch,
    input  logic            Taken,
    input  logic [TGT_W-1:0] TargetIdx,
    input  logic            MemOp,
    input  logic            MemReady,
    input  logic            Halt
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]     CycleCount
`endif
);

    seq_state_t              state_r;
    seq_state_t              state_nxt_s;
    logic [PC_W-1:0]         pc_r;
    logic [PC_W-1:0]         pc_nxt_s;
    logic                    pc_upd_s;
    logic                    br_hold_r;
    logic                    tk_hold_r;
    logic [TGT_W-1:0]        idx_hold_r;
    logic                    br_s;
    logic                    tk_s;
    logic [TGT_W-1:0]        idx_s;
    br_off_t                 lut_off_s;
    logic signed [OFF_W-1:0] off_s;

    branch_lut #(
        .TGT_W (TGT_W)
    ) u_branch_lut (
        .idx (idx_s),
        .off (lut_off_s)
    );

    // State register; Reset overrides everything else.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; Halt outranks a memory stall in EXEC.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                state_nxt_s = EXEC;
            end
            EXEC: begin
                if (Halt) begin
                    state_nxt_s = HALT;
                end else if (MemOp && !MemReady) begin
                    state_nxt_s = WAIT_MEM;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            WAIT_MEM: begin
                if (MemReady) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = WAIT_MEM;
                end
            end
            HALT: begin
                if (!Start) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode straight from the state register, never from inputs.
    always_comb begin
        Done      = (state_r == HALT);
        InstrRd   = (state_r == FETCH);
        ExecEn    = (state_r == EXEC);
        InstrAddr = pc_r;
    end

    // During a stall the branch fields come from the copy taken in EXEC.
    always_comb begin
        if (state_r == WAIT_MEM) begin
            br_s  = br_hold_r;
            tk_s  = tk_hold_r;
            idx_s = idx_hold_r;
        end else begin
            br_s  = Branch;
            tk_s  = Taken;
            idx_s = TargetIdx;
        end
    end

    // PC advance condition and the wrapped next-PC value.
    always_comb begin
        off_s = OFF_W'(lut_off_s);
        if (state_r == EXEC) begin
            pc_upd_s = !Halt && !(MemOp && !MemReady);
        end else if (state_r == WAIT_MEM) begin
            pc_upd_s = MemReady;
        end else begin
            pc_upd_s = 1'b0;
        end
        if (br_s && tk_s) begin
            pc_nxt_s = pc_r + PC_W'(off_s);
        end else begin
            pc_nxt_s = pc_r + PC_W'(1'b1);
        end
    end

    // Program counter: cleared on run start, otherwise advanced on completion.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r <= '0;
        end else if ((state_r == IDLE) && Start) begin
            pc_r <= '0;
        end else if (pc_upd_s) begin
            pc_r <= pc_nxt_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Capture the decoder's branch fields while in EXEC.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            br_hold_r  <= 1'b0;
            tk_hold_r  <= 1'b0;
            idx_hold_r <= '0;
        end else if (state_r == EXEC) begin
            br_hold_r  <= Branch;
            tk_hold_r  <= Taken;
            idx_hold_r <= TargetIdx;
        end else begin
            br_hold_r  <= br_hold_r;
            tk_hold_r  <= tk_hold_r;
            idx_hold_r <= idx_hold_r;
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cyc_r;

    // Saturating count of busy cycles in the current run.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cyc_r <= 16'h0000;
        end else if ((state_r == IDLE) && Start) begin
            cyc_r <= 16'h0000;
        end else if (((state_r == FETCH) || (state_r == EXEC) || (state_r == WAIT_MEM))
                     && (cyc_r != 16'hFFFF)) begin
            cyc_r <= cyc_r + 16'h0001;
        end else begin
            cyc_r <= cyc_r;
        end
    end

    assign CycleCount = cyc_r;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: an instruction-level model expands
// directed programs into per-cycle stimulus and expected outputs.
module tb_pc_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Start, Branch, Taken, MemOp, MemReady, Halt;
    logic [4:0] TargetIdx;
    logic       Done, InstrRd, ExecEn;
    logic [9:0] InstrAddr;
    logic [15:0] cc_act;

    int checks = 0;
    int errors = 0;

`ifdef SEQ_CYCLE_COUNT_EN
    localparam bit CC_ON = 1'b1;
    logic [15:0] CycleCount;
    assign cc_act = CycleCount;
`else
    localparam bit CC_ON = 1'b0;
    assign cc_act = 16'd0;
`endif

    pc_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Done      (Done),
        .InstrRd   (InstrRd),
        .InstrAddr (InstrAddr),
        .ExecEn    (ExecEn),
        .Branch    (Branch),
        .Taken     (Taken),
        .TargetIdx (TargetIdx),
        .MemOp     (MemOp),
        .MemReady  (MemReady),
        .Halt      (Halt)
`ifdef SEQ_CYCLE_COUNT_EN
        ,
        .CycleCount (CycleCount)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       rd;
        logic [9:0] addr;
        logic       ex;
        logic       done;
        logic [15:0] cc;
    } exp_t;

    typedef struct packed {
        logic       start, rst, br, tk;
        logic [4:0] idx;
        logic       mem, rdy, halt;
    } in_t;

    typedef struct {
        bit       br, tk;
        bit [4:0] idx;
        bit       mem;
        int       lat;
        bit       halt;
        bit       rst_wait;
    } ins_t;

    ins_t prog[$];
    exp_t exp_q[$];
    in_t  in_q[$];
    int   fetch_q[$];
    exp_t exp_cur;
    bit   chk_en = 1'b0;
    int   cur_pc = 0;
    int   cur_cc = 0;
    int   cyc = 0;

    function automatic ins_t mk(bit br, bit tk, int idx, bit mem, int lat, bit halt, bit rw);
        ins_t r;
        r.br = br; r.tk = tk; r.idx = idx[4:0]; r.mem = mem;
        r.lat = lat; r.halt = halt; r.rst_wait = rw;
        return r;
    endfunction

    function automatic int lut_off(bit [4:0] idx);
        case (idx)
            5'd0:    return 3;
            5'd1:    return -2;
            5'd2:    return 16;
            default: return 1;
        endcase
    endfunction

    function automatic void push(bit rd, int addr, bit ex, bit done, int cc, in_t iv);
        exp_t e;
        e.rd = rd; e.addr = addr[9:0]; e.ex = ex; e.done = done; e.cc = cc[15:0];
        exp_q.push_back(e);
        in_q.push_back(iv);
    endfunction

    // Instruction-level model: expands prog into one record per clock cycle.
    task automatic build(input int hold);
        int   pc, cc;
        in_t  iv;
        exp_q.delete();
        in_q.delete();
        iv = '0; iv.start = 1'b1;
        push(0, cur_pc, 0, 0, cur_cc, iv);
        pc = 0; cc = 0;
        foreach (prog[i]) begin
            iv = '0;
            iv.start = (hold != 0) ? 1'b1 : 1'(i % 2);
            push(1, pc, 0, 0, cc, iv);
            cc = (cc < 65535) ? cc + 1 : cc;
            iv.br = prog[i].br; iv.tk = prog[i].tk; iv.idx = prog[i].idx;
            iv.mem = prog[i].mem; iv.halt = prog[i].halt;
            iv.rdy = !(prog[i].mem && prog[i].lat > 0);
            push(0, pc, 1, 0, cc, iv);
            cc = (cc < 65535) ? cc + 1 : cc;
            if (prog[i].halt) break;
            if (prog[i].mem) begin
                for (int w = 1; w <= prog[i].lat; w++) begin
                    iv.halt = 1'b0;
                    iv.br = !prog[i].br; iv.tk = !prog[i].tk; iv.idx = prog[i].idx ^ 5'd2;
                    iv.rdy = (w == prog[i].lat);
                    iv.rst = prog[i].rst_wait && (w == 1);
                    push(0, pc, 0, 0, cc, iv);
                    cc = (cc < 65535) ? cc + 1 : cc;
                    if (iv.rst) begin
                        iv = '0;
                        push(0, 0, 0, 0, 0, iv);
                        push(0, 0, 0, 0, 0, iv);
                        cur_pc = 0; cur_cc = 0;
                        return;
                    end
                end
            end
            if (prog[i].br && prog[i].tk) pc = (((pc + lut_off(prog[i].idx)) % 1024) + 1024) % 1024;
            else                          pc = (pc + 1) % 1024;
        end
        iv = '0; iv.start = 1'b1;
        repeat (hold) push(0, pc, 0, 1, cc, iv);
        iv.start = 1'b0;
        push(0, pc, 0, 1, cc, iv);
        push(0, pc, 0, 0, cc, iv);
        cur_pc = pc; cur_cc = cc;
    endtask

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge Clk) begin
        if (chk_en) begin
            exp_t act, e;
            e = exp_cur;
            if (!CC_ON) e.cc = 16'd0;
            act.rd = InstrRd; act.addr = InstrAddr; act.ex = ExecEn; act.done = Done; act.cc = cc_act;
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle%0d got rd=%0b addr=%0d ex=%0b done=%0b cc=%0d want rd=%0b addr=%0d ex=%0b done=%0b cc=%0d",
                         cyc, act.rd, act.addr, act.ex, act.done, act.cc, e.rd, e.addr, e.ex, e.done, e.cc);
            end
            if (InstrRd === 1'b1) fetch_q.push_back(int'(InstrAddr));
        end
    end

    task automatic pin(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic check_fetch(input string nm, input int fx[$]);
        bit ok;
        ok = (fetch_q.size() == fx.size());
        for (int i = 0; i < fx.size() && ok; i++) ok = (fetch_q[i] == fx[i]);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s fetch got %p want %p", nm, fetch_q, fx);
        end
    endtask

    task automatic run_scen(input int hold);
        build(hold);
        fetch_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            {Start, Reset, Branch, Taken, TargetIdx, MemOp, MemReady, Halt} = in_q[k];
            exp_cur = exp_q[k];
            cyc = k;
            chk_en = 1'b1;
            @(posedge Clk);
            #1;
        end
        chk_en = 1'b0;
        {Start, Reset, Branch, Taken, TargetIdx, MemOp, MemReady, Halt} = '0;
    endtask

    initial begin
        int fx[$];
        int first_done, ex_cnt;
        {Start, Branch, Taken, TargetIdx, MemOp, MemReady, Halt} = '0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        pin("reset_instrrd", int'(InstrRd), 0);
        pin("reset_execen", int'(ExecEn), 0);
        pin("reset_done", int'(Done), 0);
        pin("reset_addr", int'(InstrAddr), 0);
        if (CC_ON) pin("reset_cyclecount", int'(cc_act), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Three plain instructions then Halt at PC=3.
        prog.delete();
        repeat (3) prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        run_scen(0);
        first_done = -1; ex_cnt = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i].ex) ex_cnt++;
            if (exp_q[i].done && first_done < 0) first_done = i;
        end
        pin("model_done_at", first_done, 9);
        pin("model_execen_cycles", ex_cnt, 4);
        pin("model_cc_halt", int'(exp_q[9].cc), 8);
        fx = '{0, 1, 2, 3};
        check_fetch("plain_halt", fx);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        pin("idle_addr_frozen", int'(InstrAddr), 3);
        pin("idle_done_low", int'(Done), 0);
        if (CC_ON) pin("cyclecount_frozen", int'(cc_act), 8);
        @(posedge Clk); #1;

        // Taken branch idx1 at PC=5 -> 3, not-taken later at PC=5 -> 6; Start held high.
        prog.delete();
        repeat (5) prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        repeat (2) prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        run_scen(5);
        fx = '{0, 1, 2, 3, 4, 5, 3, 4, 5, 6};
        check_fetch("branch_taken_nottaken", fx);

        // Wrap downward 0 -> 1022, upward 1022 -> 1; Halt beats a taken branch.
        prog.delete();
        prog.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        prog.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(1, 1, 2, 0, 0, 1, 0));
        run_scen(0);
        fx = '{0, 1022, 1, 2};
        check_fetch("branch_wrap", fx);
        pin("halt_over_branch_pc", int'(InstrAddr), 2);

        // Plain increment wraps 1023 -> 0; Halt beats a pending memory stall.
        prog.delete();
        prog.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 1, 2, 1, 0));
        run_scen(0);
        fx = '{0, 1022, 1023, 0};
        check_fetch("increment_wrap", fx);

        // Memory stalls: branch fields held from EXEC, changes during stall ignored.
        prog.delete();
        repeat (4) prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 1, 3, 0, 0));
        prog.push_back(mk(1, 1, 1, 1, 2, 0, 0));
        prog.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        run_scen(0);
        fx = '{0, 1, 2, 3, 4, 5, 3, 4};
        check_fetch("mem_stall", fx);
        pin("model_stall_len", exp_q.size(), 1 + 2 * 8 + 3 + 2 + 2);

        // Reset in WAIT_MEM returns to IDLE with PC=0.
        prog.delete();
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 1, 3, 0, 1));
        run_scen(0);
        fx = '{0, 1};
        check_fetch("reset_in_wait", fx);
        @(negedge Clk);
        pin("post_reset_addr", int'(InstrAddr), 0);
        pin("post_reset_execen", int'(ExecEn), 0);
        pin("post_reset_done", int'(Done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 9-bit-instruction core.
- Owns the program counter and drives the instruction-ROM read.
- Gates architectural writes from the control decoder via ExecEn, stalls on slow data-memory ops, applies taken-branch offsets from a LUT, and runs a Start/Done handshake with the testbench/host.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- TGT_W, 5, branch-target LUT index width.
- OFF_W, 8, signed branch offset width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level request to run the program from PC=0.
- Done  output  1  high while halted after a run.
- InstrRd  output  1  ROM read strobe.
- InstrAddr  output  PC_W  ROM address (current PC).
- ExecEn  output  1  qualifies RegWrite/MemWrite from the decoder; high only in EXEC.
- Branch  input  1  decoder branch flag for the current instruction.
- Taken  input  1  ALU branch condition.
- TargetIdx  input  TGT_W  branch LUT index from the instruction field.
- MemOp  input  1  current instruction is a load or store.
- MemReady  input  1  data memory has completed its access.
- Halt  input  1  decoder halt flag.

Behaviour:
- Reset: state=IDLE, PC=0, Done=0, InstrRd=0, ExecEn=0, and CycleCount=0 when the optional feature is present.
- Reset mid-run wins over all other activity: IDLE on the next edge, ExecEn low from that edge.
- States: IDLE, FETCH, EXEC, WAIT_MEM, HALT.
- IDLE, Start=1: PC<=0, go to FETCH. Start=0: stay.
- FETCH: InstrRd=1, InstrAddr=PC. The synchronous ROM returns data next cycle. Always go to EXEC.
- EXEC: ExecEn=1. Decoder inputs are sampled this cycle. Priority:
  - Halt: go to HALT, PC unchanged.
  - MemOp && !MemReady: go to WAIT_MEM, PC unchanged.
  - Otherwise: PC update, go to FETCH.
- WAIT_MEM: ExecEn=0. Branch/Taken/TargetIdx are held from EXEC in internal registers.
  - MemReady=1: PC update, go to FETCH.
  - Stall length is unbounded.
- PC update:
  - Branch && Taken: PC <= PC + sign_extend(LUT[TargetIdx]), truncated to PC_W (wraps both ways).
  - Otherwise: PC <= PC+1; PC = 2^PC_W-1 wraps to 0.
  - Halt has priority over Branch in the same cycle.
- HALT: Done=1, PC frozen.
  - Go to IDLE when Start=0; Done drops in IDLE.
  - If Start stays 1, remain in HALT; a rerun requires Start to go low then high.
- Start changes during FETCH/EXEC/WAIT_MEM are ignored.
- Throughput: 2 cycles per non-stalled instruction; each MemReady-low cycle in EXEC/WAIT_MEM adds 1.
- InstrAddr always equals PC, including outside FETCH.
- Outputs are registered-state decodes; no combinational path from inputs to outputs.

Optional Feature:
- Macro SEQ_CYCLE_COUNT_EN.
- Defined: adds output CycleCount (16 bits).
  - Cleared on the IDLE->FETCH transition.
  - Increments once per cycle in FETCH, EXEC or WAIT_MEM; saturates at 16'hFFFF.
  - Frozen in HALT and IDLE; cleared by Reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package seq_pkg holds:
  - enum seq_state_t {IDLE, FETCH, EXEC, WAIT_MEM, HALT};
  - default widths PC_W/TGT_W/OFF_W;
  - typedef br_off_t (signed OFF_W);
  - constant array BR_OFFSETS. Default contents: idx0=+3, idx1=-2, idx2=+16, all others +1.
- Sub-module branch_lut: combinational TargetIdx -> br_off_t lookup from BR_OFFSETS.

Test Plan:
- Reset then Start=1 with 3 plain instructions then Halt at PC=3 -> InstrAddr sequence 0,1,2,3. Done rises on the edge after EXEC of PC=3, 8 cycles after Start is sampled. ExecEn is high exactly 4 cycles.
- Branch=1, Taken=1, TargetIdx=1 at PC=5 -> next fetch at PC=3. Same with Taken=0 -> PC=6.
- Branch taken with TargetIdx=0 at PC=1022 (PC_W=10) -> PC wraps to 1. Plain instruction at PC=1023 -> PC=0.
- MemOp=1 with MemReady low for 3 cycles at PC=4 -> ExecEn for 1 cycle, 3 WAIT_MEM cycles, next fetch PC=5. Branch inputs changed during the stall are ignored.
- Reset asserted in WAIT_MEM -> next edge IDLE, PC=0, ExecEn=0, Done=0. Start held high through HALT -> Done stays 1 with no rerun until Start toggles low/high.
- SEQ_CYCLE_COUNT_EN defined, first scenario -> CycleCount=8 at HALT, unchanged 5 cycles later, reset to 0 on restart.
